// File: rtl/smvm_pkg.sv
// Shared SMVM definitions: result word width, default buffer depth and the
// frame FSM state encoding used by SMVM-side blocks.
package smvm_pkg;
    localparam int SMVM_DATA_W = 14;
    localparam int SMVM_DEPTH  = 16;
    localparam int ROW_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } smvm_state_e;
endpackage

// File: rtl/smvm_sync_fifo.sv
// Single-clock FIFO with registered storage; push/pop are self-guarded so a
// push into a full FIFO only lands when a pop happens in the same cycle.
module smvm_sync_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/smvm_result_buffer.sv
// Frame-aware result buffer behind the SMVM: tags each accepted word with its
// input row number so dropped words never shift the row labels seen downstream.
module smvm_result_buffer
    import smvm_pkg::*;
#(
    parameter int DATA_W = SMVM_DATA_W,
    parameter int DEPTH  = SMVM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rows_load,
    input  logic [7:0]               rows_in,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        data_out,
    output logic [7:0]               row_idx,
    output logic                     last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     err_unexp
);
    localparam int ENT_W = DATA_W + ROW_W;

    smvm_state_e      state;
    logic [7:0]       rows_r, in_cnt, out_cnt, drop_cnt;
    logic [ENT_W-1:0] head;
    logic             full, empty;
    logic             push_req, push, pop, drop;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_req  = (state == ST_RUN) && in_valid;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // Outputs are forced to zero whenever the FIFO is empty, including reset.
    assign data_out  = out_valid ? head[DATA_W-1:0] : '0;
    assign row_idx   = out_valid ? head[ENT_W-1:DATA_W] : '0;
    assign last      = out_valid && (row_idx == rows_r - 8'd1);

    smvm_sync_fifo #(.DATA_W(ENT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_cnt, data_in}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rows_r    <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            if (in_valid && state != ST_RUN) err_unexp <= 1'b1;
            if (drop)                        overflow  <= 1'b1;
            if (pop)                         out_cnt   <= out_cnt + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (rows_load && rows_in != 8'd0) begin
                        state    <= ST_RUN;
                        rows_r   <= rows_in;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        drop_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // Dropped words still advance in_cnt so the frame length holds.
                    if (in_valid) begin
                        in_cnt <= in_cnt + 8'd1;
                        if (drop) drop_cnt <= drop_cnt + 8'd1;
                        if (in_cnt + 8'd1 == rows_r) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Second term covers frames whose final row was dropped.
                    if ((pop && last) ||
                        (empty && in_cnt == rows_r && out_cnt + drop_cnt == rows_r))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smvm_result_buffer.sv
// Directed bench for smvm_result_buffer with a scoreboard queue of expected
// head entries, compared on every cycle the DUT presents out_valid.
module tb_smvm_result_buffer;
    import smvm_pkg::*;

    localparam int DW    = 14;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rows_load = 1'b0;
    logic [7:0]    rows_in = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic [7:0]    row_idx;
    logic          last;
    logic [4:0]    count;
    logic          overflow;
    logic          err_unexp;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [7:0]    r;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    smvm_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rows_load (rows_load),
        .rows_in   (rows_in),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .row_idx   (row_idx),
        .last      (last),
        .count     (count),
        .overflow  (overflow),
        .err_unexp (err_unexp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] n);
        rows_load = 1'b1;
        rows_in   = n;
        tick();
        rows_load = 1'b0;
    endtask

    task automatic word(input logic [DW-1:0] d, input logic [7:0] r, input bit l, input bit acc);
        in_valid = 1'b1;
        data_in  = d;
        if (acc) q.push_back({d, r, l});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit rnd);
        int i;
        i = 0;
        while (!(dut.state == ST_IDLE && count == 5'd0) && i < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        chk(tag, 32'(dut.state == ST_IDLE && count == 5'd0), 32'd1);
        chk({tag, "_sb_drained"}, 32'(q.size()), 32'd0);
    endtask

    // Head must match the oldest expected entry every valid cycle, stalled or not.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("sb_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("head_data", 32'(data_out), 32'(q[0].d));
                chk("head_row",  32'(row_idx),  32'(q[0].r));
                chk("head_last", 32'(last),     32'(q[0].l));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_row_idx",   32'(row_idx),   32'd0);
        chk("rst_last",      32'(last),      32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_err_unexp", 32'(err_unexp), 32'd0);
        rst = 1'b0;

        // Three-row frame, continuous drain.
        out_ready = 1'b1;
        load(8'd3);
        word(14'd5,    8'd0, 1'b0, 1'b1);
        word(14'h3FF9, 8'd1, 1'b0, 1'b1);
        word(14'd8191, 8'd2, 1'b1, 1'b1);
        wait_idle("t1_idle", 1'b0);
        chk("t1_overflow",  32'(overflow),  32'd0);
        chk("t1_err_unexp", 32'(err_unexp), 32'd0);

        // Stray word while idle.
        in_valid = 1'b1;
        data_in  = 14'h123;
        tick();
        in_valid = 1'b0;
        chk("t2_err_unexp", 32'(err_unexp), 32'd1);
        chk("t2_count",     32'(count),     32'd0);
        chk("t2_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t2_err_sticky", 32'(err_unexp), 32'd1);
        do_reset();
        chk("t2_err_cleared", 32'(err_unexp), 32'd0);

        // Overflow: 20 rows into 16 entries with the sink stalled.
        out_ready = 1'b0;
        load(8'd20);
        for (int i = 0; i < 20; i++) word(14'(100 + i), 8'(i), 1'b0, i < 16);
        chk("t3_count",    32'(count),     32'd16);
        chk("t3_overflow", 32'(overflow),  32'd1);
        chk("t3_state",    32'(dut.state), 32'(ST_DRAIN));
        out_ready = 1'b1;
        wait_idle("t3_idle", 1'b0);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);
        do_reset();

        // Full FIFO with simultaneous push and pop across pointer wrap.
        out_ready = 1'b0;
        load(8'd24);
        for (int i = 0; i < 16; i++) word(14'(i * 37 - 200), 8'(i), 1'b0, 1'b1);
        chk("t4_full_count", 32'(count), 32'd16);
        out_ready = 1'b1;
        for (int i = 16; i < 24; i++) begin
            word(14'(i * 37 - 200), 8'(i), i == 23, 1'b1);
            chk("t4_count_hold", 32'(count), 32'd16);
        end
        wait_idle("t4_idle", 1'b0);
        chk("t4_overflow", 32'(overflow), 32'd0);

        // Reset mid-frame, then a one-row frame.
        out_ready = 1'b0;
        load(8'd4);
        word(14'd11, 8'd0, 1'b0, 1'b1);
        word(14'd22, 8'd1, 1'b0, 1'b1);
        chk("t5_count_pre", 32'(count), 32'd2);
        do_reset();
        q.delete();
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_count",     32'(count),     32'd0);
        chk("t5_state",     32'(dut.state), 32'(ST_IDLE));
        out_ready = 1'b1;
        load(8'd1);
        word(14'd77, 8'd0, 1'b1, 1'b1);
        wait_idle("t5_idle", 1'b0);

        // Ten-row frame with a randomly stalling sink.
        load(8'd10);
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            word(14'($urandom_range(0, 16383)), 8'(i), i == 9, 1'b1);
        end
        wait_idle("t6_idle", 1'b1);
        chk("t6_overflow",  32'(overflow),  32'd0);
        chk("t6_err_unexp", 32'(err_unexp), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/smvm_result_buffer.md
SMVM_RESULT_BUFFER -- requirements
Module: smvm_result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 14, result word width; matches the SMVM data_out width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port rows_load, input, 1, a one-cycle pulse that latches rows_in and starts a frame.
REQ-006 SHALL have port rows_in, input, 8, the number of result rows expected in the frame.
REQ-007 SHALL have port in_valid, input, 1, driven by the SMVM out_valid; no backpressure upstream.
REQ-008 SHALL have port data_in, input, DATA_W, driven by the SMVM data_out; signed two's complement.
REQ-009 SHALL have port out_ready, input, 1, downstream ready.
REQ-010 SHALL have port out_valid, output, 1, head entry available.
REQ-011 SHALL have port data_out, output, DATA_W, the head entry.
REQ-012 SHALL have port row_idx, output, 8, the row number of the head entry, 0-based.
REQ-013 SHALL have port last, output, 1, high with out_valid when row_idx equals rows-1.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port overflow, output, 1, sticky: a word was dropped because the FIFO was full.
REQ-016 SHALL have port err_unexp, output, 1, sticky: in_valid was seen outside state RUN.

Function
REQ-017 SHALL implement the states IDLE, RUN and DRAIN.
REQ-018 SHALL go from IDLE to RUN on rows_load with rows_in≠0, latch rows, and clear both the input and output row counters.
REQ-019 SHALL ignore rows_load with rows_in=0 in IDLE, and ignore rows_load in RUN and DRAIN.
REQ-020 SHALL push data_in in RUN on in_valid when the FIFO is not full (or is full but popping in the same cycle), and SHALL increment the input row counter on every accepted push.
REQ-021 SHALL, in RUN, on in_valid when full and not popping, drop the word, set overflow, and still increment the input row counter so frame length is preserved.
REQ-022 SHALL go from RUN to DRAIN in the cycle the input row counter reaches rows.
REQ-023 SHALL, on in_valid in IDLE or DRAIN, discard the word, set err_unexp, and leave the counters unchanged.
REQ-024 SHALL pop when out_valid and out_ready are both high; row_idx then increments.
REQ-025 SHALL go from DRAIN to IDLE on the pop with last=1.
REQ-026 SHALL go directly to IDLE if the FIFO is empty, the input row counter equals rows, and the output row counter plus dropped words equals rows.
REQ-027 SHALL drive out_valid = count≠0, combinationally from registered state.
REQ-028 SHALL produce data_out one cycle after the push; no same-cycle bypass when empty.
REQ-029 SHALL change count by +1 on a push only, −1 on a pop only, and 0 on a simultaneous push and pop.
REQ-030 SHALL wrap the read and write pointers modulo DEPTH.
REQ-031 SHALL advance row_idx by the number of dropped words preceding the head, so that row_idx always labels true SMVM row order.
REQ-032 SHALL keep data_out, row_idx and last stable while out_valid=1 and out_ready=0.
REQ-033 SHALL carry data bit-exact; no arithmetic is applied to the data.

Reset
REQ-034 SHALL, when rst=1 at a clock edge, set state=IDLE, pointers=0, count=0, row counters=0, rows=0, overflow=0 and err_unexp=0.
REQ-035 SHALL hold out_valid=0, last=0, data_out=0 and row_idx=0 while in reset.
REQ-036 SHALL discard FIFO contents on reset mid-frame; no partial frame survives.
REQ-037 SHALL clear overflow and err_unexp only by reset.

Structure
REQ-038 SHALL place DATA_W, the default DEPTH and the state encodings (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) in a shared package smvm_pkg, reused by SMVM-side blocks.
REQ-039 SHALL build the storage as a sub-module smvm_sync_fifo (parameterised by DATA_W and DEPTH, with push/pop/full/empty/count); the frame FSM and row tagging live in the top level.

Verification
REQ-040 Directed: rows_load with rows_in=3, then 3 consecutive in_valid words 5, −7, 8191 with out_ready=1 -> outputs 5/0, −7/1, 8191/2 with last on the third, back to IDLE, no flags set.
REQ-041 Directed: rows_in=20, out_ready=0, 20 consecutive words -> count saturates at 16, 4 words dropped, overflow=1; on release the 16 outputs carry row_idx 0..15 and last is not asserted; FIFO drains to IDLE per REQ-026.
REQ-042 Directed: FIFO full with out_ready=1 and in_valid=1 in the same cycle -> count stays 16, no overflow, order preserved across pointer wrap.
REQ-043 Directed: in_valid pulse while IDLE -> err_unexp=1, count=0, no output.
REQ-044 Directed: rst pulsed mid-frame after 2 of 4 words -> out_valid=0 next cycle, state IDLE; a new rows_load with rows_in=1 and one word completes normally.
REQ-045 Directed: out_ready toggled randomly during a 10-row frame -> data_out, row_idx and last held stable across stalls, and the output sequence matches the input.
